// File: rtl/leg_bus_if.sv
// Bus bundle between the two cache controllers, the external memory port and the arbiter.
// The arbiter takes the slave view; whoever drives the masters and the memory takes the master view.
interface leg_bus_if #(
  parameter int BEATS = 4
) ();
  localparam int CW = $clog2(BEATS);

  // Data-side master
  logic          HRequestM;
  logic          HWriteM;
  logic [31:0]   HAddrM;
  logic [31:0]   HWDataM;
  // Instruction-side master
  logic          HRequestF;
  logic [31:0]   HAddrF;
  // External memory
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HREQUEST;
  logic          HWRITE;
  logic [31:0]   HADDR;
  logic [31:0]   HWDATA;
  // Returns to the masters
  logic [31:0]   HRData;
  logic          DBusReady;
  logic          IBusReady;
  logic          HLast;
  logic [CW-1:0] BeatCount;

  modport slave (
    input  HRequestM, HWriteM, HAddrM, HWDataM,
    input  HRequestF, HAddrF,
    input  HREADY, HRDATA,
    output HREQUEST, HWRITE, HADDR, HWDATA,
    output HRData, DBusReady, IBusReady, HLast, BeatCount
  );

  modport master (
    output HRequestM, HWriteM, HAddrM, HWDataM,
    output HRequestF, HAddrF,
    output HREADY, HRDATA,
    input  HREQUEST, HWRITE, HADDR, HWDATA,
    input  HRData, DBusReady, IBusReady, HLast, BeatCount
  );
endinterface

// File: rtl/leg_bus_arbiter.sv
// Two-master arbiter (data writeback side over instruction fetch side) onto one memory port.
// A grant is held while its owner keeps requesting; on release a waiting master takes over directly.
module leg_bus_arbiter #(
  parameter int BEATS = 4
) (
  input logic      clk,
  input logic      reset,
  leg_bus_if.slave bus
);
  localparam int CW = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          d_gnt, i_gnt, beat;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state: the current owner keeps the bus; on release the other master is handed it directly.
  always_comb begin
    // NOTE: a default before the case keeps this block free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if      (bus.HRequestM) state_d = DGRANT;
        else if (bus.HRequestF) state_d = IGRANT;
      end
      DGRANT: begin
        if      (bus.HRequestM) state_d = DGRANT;
        else if (bus.HRequestF) state_d = IGRANT;
        else                    state_d = IDLE;
      end
      IGRANT: begin
        if      (bus.HRequestF) state_d = IGRANT;
        else if (bus.HRequestM) state_d = DGRANT;
        else                    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the granted master's request is gated straight onto the bus, no pipeline stage.
  always_comb begin
    d_gnt = (state_q == DGRANT);
    i_gnt = (state_q == IGRANT);

    bus.HREQUEST  = (d_gnt & bus.HRequestM) | (i_gnt & bus.HRequestF);
    bus.HWRITE    = d_gnt & bus.HWriteM;
    bus.HADDR     = d_gnt ? bus.HAddrM : bus.HAddrF;
    bus.HWDATA    = bus.HWDataM;
    bus.HRData    = bus.HRDATA;
    bus.DBusReady = d_gnt & bus.HRequestM & bus.HREADY;
    bus.IBusReady = i_gnt & bus.HRequestF & bus.HREADY;

    beat          = bus.DBusReady | bus.IBusReady;
    bus.HLast     = beat & (beat_cnt_q == CW'(BEATS - 1));
    bus.BeatCount = beat_cnt_q;
  end

  // Beat counter restarts on every grant change and wraps by natural overflow.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d != state_q) beat_cnt_d = '0;
    else if (beat)          beat_cnt_d = beat_cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_leg_bus_arbiter.sv
// Directed bench for leg_bus_arbiter: reset, fetch burst, writeback/refill with handoff,
// stall, mid-burst reset and round-robin fairness.
module tb_leg_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  leg_bus_if #(.BEATS(4)) bus ();

  leg_bus_arbiter #(.BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {HREQUEST, HWRITE, DBusReady, IBusReady, HLast, BeatCount[1:0]}
  function automatic logic [6:0] flags();
    return {bus.HREQUEST, bus.HWRITE, bus.DBusReady, bus.IBusReady, bus.HLast, bus.BeatCount};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.HRequestM = 1'b0;
    bus.HRequestF = 1'b0;
    bus.HWriteM   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    reset         = 1'b0;
    bus.HRequestM = 1'b0;
    bus.HWriteM   = 1'b0;
    bus.HAddrM    = 32'h0000_0040;
    bus.HWDataM   = 32'h5555_AAAA;
    bus.HRequestF = 1'b0;
    bus.HAddrF    = 32'hAAAA_0001;
    bus.HREADY    = 1'b1;
    bus.HRDATA    = 32'h1234_5678;
    #2;
    exp = 7'b0;
    if (flags() !== exp) begin
      errors++; $display("FAIL reset_flags: got %b want %b", flags(), exp);
    end
    checks++;
    if (bus.HADDR !== 32'hAAAA_0001) begin
      errors++; $display("FAIL reset_haddr: got %h want %h", bus.HADDR, 32'hAAAA_0001);
    end
    checks++;
    if (bus.HWDATA !== 32'h5555_AAAA || bus.HRData !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_passthru: got hwdata %h hrdata %h want 5555aaaa 12345678",
                         bus.HWDATA, bus.HRData);
    end
    checks++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (flags() !== exp) begin
        errors++; $display("FAIL idle_cycle%0d: got %b want %b", i, flags(), exp);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_ifetch_burst();
    logic [6:0] exp;
    bus.HRequestF = 1'b1;
    bus.HAddrF    = 32'h0000_0100;
    bus.HREADY    = 1'b1;
    @(negedge clk);
    exp = 7'b0;
    if (flags() !== exp) begin
      errors++; $display("FAIL ifetch_latency: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b1, (i == 3), 2'(i)};
      if (flags() !== exp) begin
        errors++; $display("FAIL ifetch_beat%0d: got %b want %b", i, flags(), exp);
      end
      checks++;
      if (bus.HADDR !== 32'h0000_0100) begin
        errors++; $display("FAIL ifetch_addr%0d: got %h want %h", i, bus.HADDR, 32'h0000_0100);
      end
      checks++;
      tick();
    end
    go_idle();
  endtask

  task automatic test_writeback_refill();
    logic [6:0] exp;
    bus.HRequestM = 1'b1;
    bus.HRequestF = 1'b1;
    bus.HWriteM   = 1'b1;
    bus.HAddrM    = 32'h0000_2000;
    bus.HWDataM   = 32'hDEAD_0000;
    bus.HAddrF    = 32'h0000_0200;
    bus.HREADY    = 1'b1;
    @(negedge clk);
    exp = 7'b0;
    if (flags() !== exp) begin
      errors++; $display("FAIL wb_latency: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.HRDATA = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      exp = {1'b1, 1'b1, 1'b1, 1'b0, ((i % 4) == 3), 2'(i % 4)};
      if (flags() !== exp) begin
        errors++; $display("FAIL wb_beat%0d: got %b want %b", i, flags(), exp);
      end
      checks++;
      if (bus.HADDR !== 32'h0000_2000 || bus.HWDATA !== 32'hDEAD_0000 ||
          bus.HRData !== 32'hC0DE_0000 + 32'(i)) begin
        errors++; $display("FAIL wb_bus%0d: got addr %h wdata %h rdata %h want 00002000 dead0000 %h",
                           i, bus.HADDR, bus.HWDATA, bus.HRData, 32'hC0DE_0000 + 32'(i));
      end
      checks++;
      tick();
    end
    // Release with HREADY still high: no ready, no count, fetch waits.
    bus.HRequestM = 1'b0;
    bus.HWriteM   = 1'b0;
    @(negedge clk);
    exp = 7'b0;
    if (flags() !== exp) begin
      errors++; $display("FAIL wb_release: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    if (flags() !== exp || bus.HADDR !== 32'h0000_0200) begin
      errors++; $display("FAIL wb_handoff: got %b addr %h want %b addr 00000200",
                         flags(), bus.HADDR, exp);
    end
    checks++;
    tick();
    go_idle();
  endtask

  task automatic test_stall();
    logic [6:0] exp;
    bus.HRequestM = 1'b1;
    bus.HWriteM   = 1'b0;
    bus.HAddrM    = 32'h0000_3000;
    bus.HREADY    = 1'b0;
    @(negedge clk);
    exp = 7'b0;
    if (flags() !== exp) begin
      errors++; $display("FAIL stall_latency: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    bus.HRequestF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      if (flags() !== exp || bus.HADDR !== 32'h0000_3000) begin
        errors++; $display("FAIL stall_wait%0d: got %b addr %h want %b addr 00003000",
                           i, flags(), bus.HADDR, exp);
      end
      checks++;
      tick();
    end
    bus.HREADY = 1'b1;
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    if (flags() !== exp) begin
      errors++; $display("FAIL stall_beat: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    bus.HRequestM = 1'b0;
    @(negedge clk);
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    if (flags() !== exp) begin
      errors++; $display("FAIL stall_release: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    if (flags() !== exp) begin
      errors++; $display("FAIL stall_handoff: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    go_idle();
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] exp;
    bus.HRequestM = 1'b1;
    bus.HAddrM    = 32'h0000_4000;
    bus.HAddrF    = 32'h0000_0300;
    bus.HREADY    = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
    if (flags() !== exp) begin
      errors++; $display("FAIL midrst_before: got %b want %b", flags(), exp);
    end
    checks++;
    #1;
    reset = 1'b0;
    #1;
    exp = 7'b0;
    if (flags() !== exp || bus.HADDR !== 32'h0000_0300) begin
      errors++; $display("FAIL midrst_async: got %b addr %h want %b addr 00000300",
                         flags(), bus.HADDR, exp);
    end
    checks++;
    bus.HRequestM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    if (flags() !== exp) begin
      errors++; $display("FAIL midrst_after: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
  endtask

  task automatic test_fairness();
    logic [6:0] exp;
    bus.HRequestM = 1'b1;
    bus.HWriteM   = 1'b1;
    bus.HRequestF = 1'b1;
    bus.HAddrF    = 32'h0000_0400;
    bus.HREADY    = 1'b1;
    @(negedge clk);
    exp = 7'b0;
    if (flags() !== exp) begin
      errors++; $display("FAIL fair_latency: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    @(negedge clk);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    if (flags() !== exp) begin
      errors++; $display("FAIL fair_single_write: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    bus.HRequestM = 1'b0;
    bus.HWriteM   = 1'b0;
    tick();
    // Data side re-requests at once, but the waiting fetch owns the bus now.
    bus.HRequestM = 1'b1;
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    if (flags() !== exp || bus.HADDR !== 32'h0000_0400) begin
      errors++; $display("FAIL fair_fetch_first: got %b addr %h want %b addr 00000400",
                         flags(), bus.HADDR, exp);
    end
    checks++;
    tick();
    bus.HRequestF = 1'b0;
    tick();
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    if (flags() !== exp) begin
      errors++; $display("FAIL fair_data_back: got %b want %b", flags(), exp);
    end
    checks++;
    tick();
    go_idle();
  endtask

  initial begin
    test_reset();
    test_ifetch_burst();
    test_writeback_refill();
    test_stall();
    test_reset_mid_burst();
    test_fairness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/leg_bus_arbiter.md
# leg_bus_arbiter

Two-master arbiter between the instruction cache controller and the data writeback cache controller. It multiplexes them onto the single external memory bus port and returns a per-master BusReady. It holds a grant for as long as the owning master keeps its request asserted, so a writeback followed by a line refill is never interleaved with fetch traffic. It counts beats within each burst and flags the last beat.

## Interface
- BEATS, 4, words per cache-line burst; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- HRequestM  in  1  data-side bus request; level, held for whole transaction
- HWriteM  in  1  data-side write (valid with HRequestM)
- HAddrM  in  32  data-side word address
- HWDataM  in  32  data-side write data
- HRequestF  in  1  instruction-side request; read-only master
- HAddrF  in  32  instruction-side word address
- HREADY  in  1  memory completes current beat this cycle
- HRDATA  in  32  memory read data, valid when HREADY
- HREQUEST  out  1  bus transaction valid
- HWRITE  out  1  bus transaction is a write
- HADDR  out  32  bus address
- HWDATA  out  32  bus write data
- HRData  out  32  HRDATA broadcast to both masters
- DBusReady  out  1  beat done for data side
- IBusReady  out  1  beat done for instruction side
- HLast  out  1  final beat of a BEATS-long burst
- BeatCount  out  log2(BEATS)  beats completed in current grant, mod BEATS

## Operation
- States: IDLE, DGRANT, IGRANT (registered).
- IDLE:
  - HRequestM=1 → DGRANT. Data side wins simultaneous requests.
  - Else HRequestF=1 → IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - HRequestM=1 → stay.
  - HRequestM=0 and HRequestF=1 → IGRANT directly.
  - Otherwise → IDLE.
- IGRANT:
  - Symmetric to DGRANT. A pending HRequestM takes DGRANT directly on release.
  - Handoff on release gives round-robin fairness: neither master starves while the other keeps re-requesting.
- Granted master's request is gated combinationally onto the bus:
  - HREQUEST = (DGRANT & HRequestM) | (IGRANT & HRequestF).
  - HADDR/HWDATA/HWRITE come from the granted master.
  - HWRITE = DGRANT & HWriteM. Always 0 in IGRANT and IDLE.
  - HADDR = HAddrM in DGRANT, HAddrF otherwise. HWDATA = HWDataM always.
- Ready routing:
  - DBusReady = DGRANT & HRequestM & HREADY.
  - IBusReady = IGRANT & HRequestF & HREADY.
  - HREADY in IDLE, or with the request low, is ignored.
- HRData = HRDATA, combinational, in every state.
- BeatCount:
  - Increments on each counted beat (DBusReady | IBusReady) and wraps BEATS-1 → 0.
  - Cleared to 0 on any state change.
- HLast = counted beat & BeatCount==BEATS-1.
- Width rules:
  - BeatCount is log2(BEATS) bits; wrap is natural overflow.
  - No other arithmetic.

## Timing
- Reset (reset=0, asynchronous):
  - State IDLE, BeatCount 0.
  - Hence HREQUEST=0, HWRITE=0, DBusReady=0, IBusReady=0, HLast=0.
  - HADDR=HAddrF, HWDATA=HWDataM, HRData=HRDATA (pass-through).
  - Reset mid-burst abandons the burst; no beat is reported after assertion.
- Arbitration latency:
  - Request first seen in IDLE in cycle N → grant and HREQUEST in cycle N+1.
  - The earliest ready is therefore N+1.
- Beats complete in the same cycle HREADY is high. There is no added pipeline delay on ready or data.
- Release:
  - Request low in cycle N → state changes at the edge ending N.
  - A handoff master sees HREQUEST in N+1 with no idle bubble.
- A request dropping while HREADY=1 in the same cycle produces no ready and no count.
- The bus requires HADDR/HWRITE/HWDATA stable while HREQUEST=1 and HREADY=0. The arbiter guarantees this by never switching grant while the owner requests.

## Test plan
- Reset, then both requests low for 3 cycles → HREQUEST=0, BeatCount=0, all readys 0.
- HRequestF=1, HAddrF=0x100, HREADY=1 every cycle for 4 cycles:
  - Grant in the cycle after request.
  - IBusReady on 4 consecutive cycles, BeatCount 0,1,2,3.
  - HLast on the 4th beat, HWRITE=0.
- HRequestM and HRequestF rise together, HWriteM=1, HAddrM=0x2000:
  - DGRANT taken, HWRITE=1, HADDR=0x2000.
  - After 8 beats (writeback+refill, request held), HRequestM drops → IGRANT next cycle with no idle cycle.
  - HLast pulses on beats 4 and 8.
- DGRANT with HREADY held low 5 cycles:
  - HREQUEST stays 1, address stable, no ready.
  - HRequestF asserted meanwhile is not granted.
- Reset asserted mid-burst at BeatCount=2 → immediate IDLE, BeatCount=0, HREQUEST=0 before the next edge.
- Single-word uncached data write (request held 1 beat) followed immediately by a re-request from the data side while fetch waits → instruction side is granted first.
